// File: rtl/audio_dac_feeder_if.sv
// audio_dac_feeder_if
//   Groups the producer handshake (sample pair in, ready out) and the
//   audio-core register bus. Clock and reset stay outside as plain ports.
//   slave  : the feeder's view (drives sample_ready and the bus strobes).
//   master : the opposite view (producer + audio core).
interface audio_dac_feeder_if;
  logic        sample_valid;
  logic [31:0] sample_left;
  logic [31:0] sample_right;
  logic        sample_ready;
  logic [1:0]  audio_slave_address;
  logic        audio_slave_chipselect;
  logic        audio_slave_read;
  logic        audio_slave_write;
  logic [31:0] audio_slave_writedata;
  logic [31:0] audio_slave_readdata;

  modport slave (
    input  sample_valid, sample_left, sample_right, audio_slave_readdata,
    output sample_ready, audio_slave_address, audio_slave_chipselect,
           audio_slave_read, audio_slave_write, audio_slave_writedata
  );

  modport master (
    output sample_valid, sample_left, sample_right, audio_slave_readdata,
    input  sample_ready, audio_slave_address, audio_slave_chipselect,
           audio_slave_read, audio_slave_write, audio_slave_writedata
  );
endinterface

// File: rtl/audio_dac_feeder.sv
// audio_dac_feeder
//   Takes stereo sample pairs from a producer and writes them into the
//   left/right FIFOs of an audio core over its register bus. Before each
//   pair it polls the FIFO-space register and only writes once both FIFOs
//   report at least MIN_SPACE free words; left and right of a pair go out
//   on back-to-back cycles.
// Ports
//   sys_clk_clk        : clock, rising edge
//   sys_reset_reset_n  : async active-low reset
//   bus (slave)        : sample handshake + audio core register bus
//   busy               : high in every state except IDLE
//   stall_count        : retry counter, only with AUDIO_DAC_FEEDER_STALL_CNT_EN
// Optional feature macro: AUDIO_DAC_FEEDER_STALL_CNT_EN
module audio_dac_feeder #(
  parameter int unsigned MIN_SPACE = 1
) (
  input  logic                sys_clk_clk,
  input  logic                sys_reset_reset_n,
  audio_dac_feeder_if.slave   bus,
  output logic                busy
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  typedef enum logic [2:0] {
    S_CLR, S_REL, S_IDLE, S_POLL, S_WAIT, S_WR_L, S_WR_R
  } state_t;

  state_t      state;
  logic [31:0] left_q;
  logic [31:0] right_q;
  logic        space_ok;
  logic        unused_rd;

  // FIFO-space register: [31:24] right free words, [23:16] left free words.
  assign space_ok = ({24'd0, bus.audio_slave_readdata[31:24]} >= MIN_SPACE) &&
                    ({24'd0, bus.audio_slave_readdata[23:16]} >= MIN_SPACE);
  // Low half of the space register carries read-side levels we don't use.
  assign unused_rd = ^bus.audio_slave_readdata[15:0];

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      state   <= S_CLR;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      case (state)
        S_CLR:  state <= S_REL;
        S_REL:  state <= S_IDLE;
        S_IDLE: if (bus.sample_valid) begin
                  left_q  <= bus.sample_left;
                  right_q <= bus.sample_right;
                  state   <= S_POLL;
                end
        S_POLL: state <= S_WAIT;
        // readdata answers the POLL read here, so the decision is taken
        // at the end of WAIT; a failed check re-polls with no idle gap.
        S_WAIT: state <= space_ok ? S_WR_L : S_POLL;
        S_WR_L: state <= S_WR_R;
        S_WR_R: state <= S_IDLE;
        default: state <= S_CLR;
      endcase
    end
  end

`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n)
      stall_count <= '0;
    else if (state == S_WAIT && !space_ok && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

  // Moore decode. The reset state is CLR, so strobes are gated with reset
  // to keep the bus quiet while reset is held and let the CLR write appear
  // in the very first cycle after release.
  always_comb begin
    bus.audio_slave_chipselect = 1'b0;
    bus.audio_slave_read       = 1'b0;
    bus.audio_slave_write      = 1'b0;
    bus.audio_slave_address    = 2'd0;
    bus.audio_slave_writedata  = 32'h0;
    if (sys_reset_reset_n) begin
      case (state)
        S_CLR: begin
          bus.audio_slave_chipselect = 1'b1;
          bus.audio_slave_write      = 1'b1;
          bus.audio_slave_writedata  = 32'h0000_000C;  // clear both FIFOs
        end
        S_REL: begin
          bus.audio_slave_chipselect = 1'b1;
          bus.audio_slave_write      = 1'b1;
        end
        S_POLL: begin
          bus.audio_slave_chipselect = 1'b1;
          bus.audio_slave_read       = 1'b1;
          bus.audio_slave_address    = 2'd1;
        end
        S_WR_L: begin
          bus.audio_slave_chipselect = 1'b1;
          bus.audio_slave_write      = 1'b1;
          bus.audio_slave_address    = 2'd2;
          bus.audio_slave_writedata  = left_q;
        end
        S_WR_R: begin
          bus.audio_slave_chipselect = 1'b1;
          bus.audio_slave_write      = 1'b1;
          bus.audio_slave_address    = 2'd3;
          bus.audio_slave_writedata  = right_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.sample_ready = (state == S_IDLE);
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_audio_dac_feeder.sv
// tb_audio_dac_feeder
//   Self-checking bench. The model turns each accepted pair into the bus
//   cycle sequence it must produce (poll/wait per FIFO-space answer, then
//   left/right writes) and a single compare step checks every cycle.
//   A second instance with MIN_SPACE=4 checks the threshold boundary.
module tb_audio_dac_feeder;
  localparam int MS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_dac_feeder_if dif ();
  audio_dac_feeder_if dif4 ();
  logic busy, busy4;
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_count, stall4;
`endif

  audio_dac_feeder #(.MIN_SPACE(MS)) u_dut (
    .sys_clk_clk(clk), .sys_reset_reset_n(rst_n), .bus(dif.slave), .busy(busy)
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  audio_dac_feeder #(.MIN_SPACE(4)) u_dut4 (
    .sys_clk_clk(clk), .sys_reset_reset_n(rst_n), .bus(dif4.slave), .busy(busy4)
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    , .stall_count(stall4)
`endif
  );

  typedef struct {
    logic [38:0] v;       // {ready, busy, cs, rd, wr, addr, wdata}
    bit          idle;
    bit          has_resp;
    logic [31:0] resp;
    bit          fail;
    bit          wrl;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] dir_q[$];
  logic [31:0] wl_log[$];
  logic [31:0] wr_log[$];
  int          n_reads = 0;
  int          checks = 0;
  int          errors = 0;
  int          stall_m = 0;
  int          pairs_acc = 0;
  int          prod_mode = 0;   // 0 manual, 1 continuous, 2 random
  int          free_mode = 0;   // 0 space always free, 1 random shortage
  bit          in_reset = 1'b1;
  bit          rst_on_wrl = 1'b0;
  bit          last_acc = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic cyc_t mk(bit rdy, bit bsy, bit cs, bit rd, bit wr,
                              logic [1:0] a, logic [31:0] d);
    cyc_t c;
    c.v = {rdy, bsy, cs, rd, wr, a, d};
    c.idle = rdy; c.has_resp = 0; c.resp = '0; c.fail = 0;
    c.wrl = wr && (a == 2'd2);
    return c;
  endfunction

  function automatic logic [31:0] pass_resp();
    return {8'($urandom_range(MS, 255)), 8'($urandom_range(MS, 255)), 16'($urandom)};
  endfunction

  function automatic logic [31:0] fail_resp();
    logic [7:0] a, b;
    a = 8'($urandom_range(MS, 255));
    b = 8'($urandom_range(MS, 255));
    case ($urandom_range(0, 2))
      0:       a = 8'($urandom_range(0, MS - 1));
      1:       b = 8'($urandom_range(0, MS - 1));
      default: begin a = 8'($urandom_range(0, MS - 1)); b = 8'($urandom_range(0, MS - 1)); end
    endcase
    return {a, b, 16'($urandom)};
  endfunction

  // One accepted pair -> expected bus cycles.
  task automatic push_pair(logic [31:0] l, logic [31:0] r);
    logic [31:0] rs[$];
    cyc_t c;
    int nf;
    if (dir_q.size() > 0) begin
      rs = dir_q; dir_q.delete();
    end else begin
      nf = (free_mode != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int i = 0; i < nf; i++) rs.push_back(fail_resp());
      rs.push_back(pass_resp());
    end
    foreach (rs[i]) begin
      exp_q.push_back(mk(0, 1, 1, 1, 0, 2'd1, 32'h0));
      c = mk(0, 1, 0, 0, 0, 2'd0, 32'h0);
      c.has_resp = 1; c.resp = rs[i];
      c.fail = !(int'(rs[i][31:24]) >= MS && int'(rs[i][23:16]) >= MS);
      exp_q.push_back(c);
    end
    exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd2, l));
    exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd3, r));
  endtask

  task automatic drive_next();
    case (prod_mode)
      1:       dif.sample_valid = 1'b1;
      2:       dif.sample_valid = ($urandom_range(0, 2) != 0);
      default: dif.sample_valid = 1'b0;
    endcase
    dif.sample_left  = $urandom;
    dif.sample_right = $urandom;
  endtask

  // One clock: compare at negedge, model update, new inputs after posedge.
  task automatic step();
    cyc_t e;
    logic [38:0] act;
    bit acc;
    @(negedge clk);
    if (in_reset) e = mk(0, 1, 0, 0, 0, 2'd0, 32'h0);
    else if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = mk(1, 0, 0, 0, 0, 2'd0, 32'h0);
    dif.audio_slave_readdata = e.has_resp ? e.resp : 32'h0;
    act = {dif.sample_ready, busy, dif.audio_slave_chipselect, dif.audio_slave_read,
           dif.audio_slave_write, dif.audio_slave_address, dif.audio_slave_writedata};
    chk("bus", 64'(act), 64'(e.v));
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    chk("stall_count", 64'(stall_count), 64'(stall_m));
`endif
    if (e.fail && stall_m < 65535) stall_m++;
    acc = e.idle && dif.sample_valid;
    last_acc = acc;
    if (acc) begin
      push_pair(dif.sample_left, dif.sample_right);
      pairs_acc++;
    end
    if (rst_on_wrl && e.wrl) begin
      rst_on_wrl = 0;
      rst_n = 1'b0; in_reset = 1'b1; exp_q.delete(); stall_m = 0;
      dif.sample_valid = 1'b0;
      #1;
      act = {dif.sample_ready, busy, dif.audio_slave_chipselect, dif.audio_slave_read,
             dif.audio_slave_write, dif.audio_slave_address, dif.audio_slave_writedata};
      chk("rst_async", 64'(act), 64'(mk(0, 1, 0, 0, 0, 2'd0, 32'h0).v));
    end
    @(posedge clk); #1;
    if (acc || !dif.sample_valid) drive_next();
  endtask

  // Called just after a posedge so the CLR write fills the next full cycle.
  task automatic release_rst();
    rst_n = 1'b1; in_reset = 1'b0;
    exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd0, 32'h0000_000C));
    exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd0, 32'h0));
  endtask

  always @(negedge clk) begin
    if (dif.audio_slave_read) n_reads++;
    if (dif.audio_slave_write && dif.audio_slave_address == 2'd2) wl_log.push_back(dif.audio_slave_writedata);
    if (dif.audio_slave_write && dif.audio_slave_address == 2'd3) wr_log.push_back(dif.audio_slave_writedata);
  end

  // MIN_SPACE=4 instance: 0x0304 must retry, 0x0404 must proceed.
  initial begin : ms4
    int nrd, nrd_at_l;
    bit prev_rd, got_l, got_r;
    logic [31:0] l4, r4;
    nrd = 0; nrd_at_l = 0; prev_rd = 0; got_l = 0; got_r = 0; l4 = '0; r4 = '0;
    dif4.sample_valid = 1'b1;
    dif4.sample_left = 32'h0BAD_F00D;
    dif4.sample_right = 32'h600D_CAFE;
    dif4.audio_slave_readdata = 32'h0;
    @(posedge rst_n);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      dif4.audio_slave_readdata = prev_rd ? ((nrd == 1) ? 32'h0304_0000 : 32'h0404_0000) : 32'h0;
      prev_rd = dif4.audio_slave_read;
      if (dif4.audio_slave_read) nrd++;
      if (dif4.audio_slave_write && dif4.audio_slave_address == 2'd2 && !got_l) begin
        got_l = 1; l4 = dif4.audio_slave_writedata; nrd_at_l = nrd;
      end
      if (dif4.audio_slave_write && dif4.audio_slave_address == 2'd3 && !got_r) begin
        got_r = 1; r4 = dif4.audio_slave_writedata;
      end
      if (got_r) dif4.sample_valid = 1'b0;
    end
    chk("ms4_polls", 64'(nrd_at_l), 64'd2);
    chk("ms4_left", 64'(l4), 64'h0BAD_F00D);
    chk("ms4_right", 64'(r4), 64'h600D_CAFE);
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    chk("ms4_stall", 64'(stall4), 64'd1);
`endif
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, base, r0;
    dif.sample_valid = 1'b0;
    dif.sample_left = '0;
    dif.sample_right = '0;
    dif.audio_slave_readdata = '0;

    // reset held
    repeat (3) step();
    release_rst();
    repeat (4) step();   // CLR, REL, then idle

    // single pair, space free
    dif.sample_valid = 1'b1;
    dif.sample_left = 32'h1234_5600;
    dif.sample_right = 32'hABCD_EF00;
    dir_q = '{32'h8080_0000};
    step();
    chk("req034_accept", 64'(last_acc), 64'd1);
    n = 1;
    while (!dif.sample_ready && n < 20) begin step(); n++; end
    chk("req034_interval", 64'(n), 64'd5);
    chk("req034_left", 64'(wl_log[$]), 64'h1234_5600);
    chk("req034_right", 64'(wr_log[$]), 64'hABCD_EF00);

    // three shortages then space
    r0 = n_reads;
    dif.sample_valid = 1'b1;
    dif.sample_left = 32'h0000_1100;
    dif.sample_right = 32'h0000_2200;
    dir_q = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0101_0000};
    step();
    n = 0;
    while (!dif.sample_ready && n < 40) begin step(); n++; end
    chk("req035_polls", 64'(n_reads - r0), 64'd4);
    chk("req035_left", 64'(wl_log[$]), 64'h0000_1100);
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    chk("req035_stall", 64'(stall_count), 64'd3);
`endif

    // reset in WR_L discards the pair
    base = wr_log.size();
    dif.sample_valid = 1'b1;
    dif.sample_left = 32'hDEAD_0001;
    dif.sample_right = 32'hDEAD_0002;
    dir_q = '{32'hFFFF_0000};
    rst_on_wrl = 1'b1;
    n = 0;
    while (!in_reset && n < 20) begin step(); n++; end
    chk("req037_reset_hit", 64'(in_reset), 64'd1);
    repeat (2) step();
    release_rst();
    repeat (4) step();
    chk("req037_no_right", 64'(wr_log.size()), 64'(base));

    // 100 back-to-back pairs, space always free
    base = wl_log.size();
    r0 = pairs_acc;
    prod_mode = 1; free_mode = 0;
    drive_next();
    n = 0;
    while (pairs_acc - r0 < 100 && n < 1000) begin step(); n++; end
    prod_mode = 0; dif.sample_valid = 1'b0;
    repeat (6) step();
    chk("req038_pairs", 64'(wl_log.size() - base), 64'd100);
`ifdef AUDIO_DAC_FEEDER_STALL_CNT_EN
    chk("req038_stall", 64'(stall_count), 64'd0);
`endif

    // random producer and random FIFO shortages
    r0 = pairs_acc;
    prod_mode = 2; free_mode = 1;
    drive_next();
    n = 0;
    while (pairs_acc - r0 < 150 && n < 5000) begin step(); n++; end
    chk("random_done", 64'(pairs_acc - r0 >= 150), 64'd1);
    prod_mode = 0; dif.sample_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin step(); n++; end
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_dac_feeder.md
AUDIO_DAC_FEEDER -- requirements
Module: audio_dac_feeder

Interface
REQ-001 SHALL provide parameter MIN_SPACE, default 1, minimum free words required in both write FIFOs (left and right) before a sample pair is written.
REQ-002 SHALL have port sys_clk_clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port sys_reset_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port sample_valid  input  1  producer presents a stereo sample pair.
REQ-005 SHALL have port sample_left  input  32  left sample, left-justified.
REQ-006 SHALL have port sample_right  input  32  right sample, left-justified.
REQ-007 SHALL have port sample_ready  output  1  feeder accepts the pair this cycle.
REQ-008 SHALL have port audio_slave_address  output  2  audio core register select.
REQ-009 SHALL have port audio_slave_chipselect  output  1  bus access strobe.
REQ-010 SHALL have port audio_slave_read  output  1  read strobe.
REQ-011 SHALL have port audio_slave_write  output  1  write strobe.
REQ-012 SHALL have port audio_slave_writedata  output  32  write data.
REQ-013 SHALL have port audio_slave_readdata  input  32  read data, valid exactly one cycle after the read strobe.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a Moore FSM with states CLR, REL, IDLE, POLL, WAIT, WR_L, WR_R; all bus outputs SHALL be decoded from the state register only.
REQ-016 In CLR: chipselect=1, write=1, address=0, writedata=0x0000_000C (clear both FIFOs); next state REL.
REQ-017 In REL: chipselect=1, write=1, address=0, writedata=0x0000_0000; next state IDLE.
REQ-018 In IDLE: sample_ready=1; on sample_valid=1, latch sample_left/sample_right into internal registers and go to POLL; otherwise stay.
REQ-019 sample_ready SHALL be 0 in every state other than IDLE; sample_valid outside IDLE SHALL be ignored and the producer SHALL hold data.
REQ-020 In POLL: chipselect=1, read=1, address=1 for exactly one cycle; next state WAIT.
REQ-021 In WAIT: no strobes; capture readdata; WSRC=readdata[31:24], WSLC=readdata[23:16], compared unsigned, 8 bits.
REQ-022 In WAIT: if WSRC>=MIN_SPACE and WSLC>=MIN_SPACE go to WR_L, else go to POLL (retry, no idle gap).
REQ-023 In WR_L: chipselect=1, write=1, address=2, writedata=latched left; next state WR_R.
REQ-024 In WR_R: chipselect=1, write=1, address=3, writedata=latched right; next state IDLE.
REQ-025 read and write SHALL never be high in the same cycle; writedata SHALL be 0 whenever write=0.
REQ-026 Minimum accept-to-accept interval SHALL be 5 cycles (IDLE, POLL, WAIT, WR_L, WR_R).
REQ-027 Left and right of one pair SHALL always be written on consecutive cycles, left first; a pair SHALL never be split across polls.

Reset
REQ-028 While sys_reset_reset_n=0: state=CLR, sample_ready=0, busy=1, all bus strobes 0, address=0, writedata=0, latched samples=0.
REQ-029 Reset asserted mid-operation SHALL discard the latched pair; after release the FSM SHALL re-run CLR, REL before accepting samples.
REQ-030 First cycle after reset release SHALL be the CLR write.

Configuration
REQ-031 Macro AUDIO_DAC_FEEDER_STALL_CNT_EN, when defined, SHALL add output stall_count (16 bits) incremented on every WAIT->POLL retry, saturating at 0xFFFF, reset to 0.
REQ-032 Without AUDIO_DAC_FEEDER_STALL_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, sample_valid=0 -> write addr 0 data 0x0C, then write addr 0 data 0x00, then sample_ready=1, busy=0.
REQ-034 Pair L=0x12345600, R=0xABCDEF00, readdata=0x8080_0000 -> read addr 1, one idle cycle, write addr 2 0x12345600, write addr 3 0xABCDEF00, ready again 5 cycles after accept.
REQ-035 readdata=0x8000_0000 (WSLC=0) for 3 polls then 0x0101_0000 -> 4 POLL reads, writes follow last poll; stall_count=3 with macro defined.
REQ-036 MIN_SPACE=4, readdata=0x0304_0000 -> retry; 0x0404_0000 -> writes proceed.
REQ-037 Reset asserted during WR_L -> strobes 0 immediately; after release CLR/REL sequence, no write to addr 3 of the discarded pair.
REQ-038 Continuous sample_valid=1, FIFO always free, 100 pairs -> 100 address-2/3 write pairs in order, no read/write overlap, stall_count=0.
